// File: rtl/elm_pkg.sv
// Shared constants and FSM encoding for the ELM classifier output stages.
package elm_pkg;

    localparam int N_CLASS = 10;
    localparam int SCORE_W = 32;
    localparam int CLS_AW  = 4;

    typedef enum logic [1:0] {
        M3_IDLE = 2'd0,
        M3_SCAN = 2'd1,
        M3_DONE = 2'd2
    } m3_state_t;

endpackage

// File: rtl/elm_max_cmp.sv
// Combinational compare-and-select of two (score, index) pairs.
// The candidate wins only when strictly greater, so ties keep the incumbent.
module elm_max_cmp #(
    parameter int D_WIDTH = 32,
    parameter int A_WIDTH = 4
) (
    input  logic signed [D_WIDTH-1:0] cur_val,
    input  logic        [A_WIDTH-1:0] cur_idx,
    input  logic signed [D_WIDTH-1:0] cand_val,
    input  logic        [A_WIDTH-1:0] cand_idx,
    output logic signed [D_WIDTH-1:0] sel_val,
    output logic        [A_WIDTH-1:0] sel_idx
);

    logic cand_gt;

    assign cand_gt = (cand_val > cur_val);
    assign sel_val = cand_gt ? cand_val : cur_val;
    assign sel_idx = cand_gt ? cand_idx : cur_idx;

endmodule

// File: rtl/elm_argmax_m3.sv
// M3 stage: scans the M2 class scores and reports the arg-max and its score.
// Define ELM_M3_MARGIN_EN to also track the runner-up and output the winning margin.
module elm_argmax_m3 #(
    parameter int N_CLASS = elm_pkg::N_CLASS,
    parameter int D_WIDTH = elm_pkg::SCORE_W,
    parameter int A_WIDTH = elm_pkg::CLS_AW
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [D_WIDTH-1:0] regf_data,
    output logic        [A_WIDTH-1:0] raddr,
    output logic                      OVER,
    output logic                      busy,
    output logic        [A_WIDTH-1:0] class_idx,
    output logic signed [D_WIDTH-1:0] max_val,
    output logic                      result_valid
`ifdef ELM_M3_MARGIN_EN
    ,
    output logic        [D_WIDTH-1:0] margin
`endif
);

    import elm_pkg::*;

    localparam logic [A_WIDTH-1:0] LAST = A_WIDTH'(N_CLASS - 1);

    m3_state_t                 state;
    logic        [A_WIDTH-1:0] k;
    logic signed [D_WIDTH-1:0] run_val;
    logic        [A_WIDTH-1:0] run_idx;
    logic signed [D_WIDTH-1:0] sel_val;
    logic        [A_WIDTH-1:0] sel_idx;
    logic signed [D_WIDTH-1:0] nxt_val;
    logic        [A_WIDTH-1:0] nxt_idx;
    logic                      first;

    // The counter doubles as the read address; it sits at 0 outside SCAN.
    assign raddr = k;
    assign first = (k == '0);

    elm_max_cmp #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_cmp_max (
        .cur_val (run_val),
        .cur_idx (run_idx),
        .cand_val(regf_data),
        .cand_idx(k),
        .sel_val (sel_val),
        .sel_idx (sel_idx)
    );

    assign nxt_val = first ? regf_data : sel_val;
    assign nxt_idx = first ? k         : sel_idx;

`ifdef ELM_M3_MARGIN_EN
    localparam logic signed [D_WIDTH-1:0] SCORE_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};

    logic signed [D_WIDTH-1:0] run2_val;
    logic signed [D_WIDTH-1:0] sel2_val;
    logic        [A_WIDTH-1:0] sel2_idx;
    logic signed [D_WIDTH-1:0] nxt2_val;

    function automatic logic [D_WIDTH-1:0] sat_margin(
        input logic signed [D_WIDTH-1:0] hi,
        input logic signed [D_WIDTH-1:0] lo
    );
        logic signed [D_WIDTH:0] diff;
        diff = {hi[D_WIDTH-1], hi} - {lo[D_WIDTH-1], lo};
        if (diff < 0)
            return '0;
        else if (diff[D_WIDTH])
            return '1;
        else
            return diff[D_WIDTH-1:0];
    endfunction

    elm_max_cmp #(.D_WIDTH(D_WIDTH), .A_WIDTH(A_WIDTH)) u_cmp_runner (
        .cur_val (run2_val),
        .cur_idx ('0),
        .cand_val(regf_data),
        .cand_idx(k),
        .sel_val (sel2_val),
        .sel_idx (sel2_idx)
    );

    // A new max (its index is the current k, since run_idx < k) demotes the old max.
    assign nxt2_val = first           ? SCORE_MIN :
                      (nxt_idx == k)  ? run_val   : sel2_val;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= M3_IDLE;
            k            <= '0;
            run_val      <= '0;
            run_idx      <= '0;
            class_idx    <= '0;
            max_val      <= '0;
            OVER         <= 1'b0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
`ifdef ELM_M3_MARGIN_EN
            run2_val     <= '0;
            margin       <= '0;
`endif
        end else begin
            case (state)
                M3_IDLE: begin
                    OVER <= 1'b0;
                    if (start) begin
                        state        <= M3_SCAN;
                        k            <= '0;
                        busy         <= 1'b1;
                        result_valid <= 1'b0;
                    end
                end
                M3_SCAN: begin
                    run_val <= nxt_val;
                    run_idx <= nxt_idx;
`ifdef ELM_M3_MARGIN_EN
                    run2_val <= nxt2_val;
`endif
                    if (k == LAST) begin
                        state        <= M3_DONE;
                        k            <= '0;
                        class_idx    <= nxt_idx;
                        max_val      <= nxt_val;
                        OVER         <= 1'b1;
                        result_valid <= 1'b1;
`ifdef ELM_M3_MARGIN_EN
                        margin       <= sat_margin(nxt_val, nxt2_val);
`endif
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                M3_DONE: begin
                    state <= M3_IDLE;
                    OVER  <= 1'b0;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= M3_IDLE;
                    OVER  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_elm_argmax_m3.sv
// Directed self-checking bench for elm_argmax_m3 (margin checks when ELM_M3_MARGIN_EN is defined).
module tb_elm_argmax_m3;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic signed [31:0] regf_data;
    logic        [3:0]  raddr;
    logic               OVER;
    logic               busy;
    logic        [3:0]  class_idx;
    logic signed [31:0] max_val;
    logic               result_valid;
`ifdef ELM_M3_MARGIN_EN
    logic        [31:0] margin;
`endif

    logic signed [31:0] scores [0:15];
    int n_pass  = 0;
    int n_total = 0;

    elm_argmax_m3 dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .regf_data   (regf_data),
        .raddr       (raddr),
        .OVER        (OVER),
        .busy        (busy),
        .class_idx   (class_idx),
        .max_val     (max_val),
        .result_valid(result_valid)
`ifdef ELM_M3_MARGIN_EN
        ,
        .margin      (margin)
`endif
    );

    always #5 clk = ~clk;

    always_comb regf_data = scores[raddr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_scores();
        for (int i = 0; i < 16; i++) scores[i] = '0;
    endtask

    // Drives one start, then steps until OVER (bounded). lat counts edges after the accept edge.
    task automatic scan_drive(input bit hold, output int lat, output bit addr_ok, output bit rv0);
        bit hit;
        start = 1'b1;
        tick();
        rv0 = result_valid;
        if (!hold) start = 1'b0;
        lat = 0;
        addr_ok = 1'b1;
        hit = 1'b0;
        for (int c = 0; c < 30 && !hit; c++) begin
            if (OVER === 1'b1) begin
                hit = 1'b1;
            end else begin
                if (c < 10 && raddr !== 4'(c)) addr_ok = 1'b0;
                tick();
                lat++;
            end
        end
        if (!hit) lat = -1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        repeat (3) tick();
        n_total++; if (OVER !== 1'b0) $display("FAIL reset_over got=%0b exp=0", OVER); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL reset_busy got=%0b exp=0", busy); else n_pass++;
        n_total++; if (raddr !== 4'd0) $display("FAIL reset_raddr got=%0d exp=0", raddr); else n_pass++;
        n_total++; if (class_idx !== 4'd0) $display("FAIL reset_class got=%0d exp=0", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd0) $display("FAIL reset_max got=%0d exp=0", max_val); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL reset_rv got=%0b exp=0", result_valid); else n_pass++;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_distinct();
        int lat; bit ok; bit rv0;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 32'(i * 10);
        scores[7] = 32'sd5000;
        scan_drive(1'b0, lat, ok, rv0);
        n_total++; if (lat !== 10) $display("FAIL distinct_latency got=%0d exp=10", lat); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL distinct_raddr_steps got=%0b exp=1", ok); else n_pass++;
        n_total++; if (busy !== 1'b1) $display("FAIL distinct_busy_done got=%0b exp=1", busy); else n_pass++;
        n_total++; if (class_idx !== 4'd7) $display("FAIL distinct_class got=%0d exp=7", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd5000) $display("FAIL distinct_max got=%0d exp=5000", max_val); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL distinct_rv got=%0b exp=1", result_valid); else n_pass++;
`ifdef ELM_M3_MARGIN_EN
        n_total++; if (margin !== 32'd4910) $display("FAIL distinct_margin got=%0d exp=4910", margin); else n_pass++;
`endif
        tick();
        n_total++; if (OVER !== 1'b0) $display("FAIL distinct_over_pulse got=%0b exp=0", OVER); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL distinct_busy_idle got=%0b exp=0", busy); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL distinct_rv_held got=%0b exp=1", result_valid); else n_pass++;
    endtask

    task automatic test_negative();
        int lat; bit ok; bit rv0;
        clear_scores();
        scores[0] = 32'sh8000_0000;
        scores[1] = -32'sd12;
        scores[2] = -32'sd13;
        scores[3] = -32'sd14;
        scores[4] = -32'sd10;
        scores[5] = -32'sd11;
        scores[6] = -32'sd20;
        scores[7] = -32'sd30;
        scores[8] = -32'sd40;
        scores[9] = -32'sd50;
        scan_drive(1'b0, lat, ok, rv0);
        n_total++; if (lat !== 10) $display("FAIL neg_latency got=%0d exp=10", lat); else n_pass++;
        n_total++; if (class_idx !== 4'd4) $display("FAIL neg_class got=%0d exp=4", class_idx); else n_pass++;
        n_total++; if (max_val !== -32'sd10) $display("FAIL neg_max got=%0d exp=-10", max_val); else n_pass++;
`ifdef ELM_M3_MARGIN_EN
        n_total++; if (margin !== 32'd1) $display("FAIL neg_margin got=%0d exp=1", margin); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_tie();
        int lat; bit ok; bit rv0;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 32'(100 + i);
        scores[2] = 32'sd300;
        scores[5] = 32'sd300;
        scan_drive(1'b0, lat, ok, rv0);
        n_total++; if (class_idx !== 4'd2) $display("FAIL tie_class got=%0d exp=2", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd300) $display("FAIL tie_max got=%0d exp=300", max_val); else n_pass++;
`ifdef ELM_M3_MARGIN_EN
        n_total++; if (margin !== 32'd0) $display("FAIL tie_margin got=%0d exp=0", margin); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        int lat; bit ok; bit rv0;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 32'(i * 10);
        scores[0] = 32'sd900;
        scan_drive(1'b1, lat, ok, rv0);
        n_total++; if (class_idx !== 4'd0) $display("FAIL b2b_first_class got=%0d exp=0", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd900) $display("FAIL b2b_first_max got=%0d exp=900", max_val); else n_pass++;
`ifdef ELM_M3_MARGIN_EN
        n_total++; if (margin !== 32'd810) $display("FAIL b2b_first_margin got=%0d exp=810", margin); else n_pass++;
`endif
        for (int i = 0; i < 10; i++) scores[i] = 32'(i);
        scores[9] = 32'sd700;
        tick();
        n_total++; if (busy !== 1'b0) $display("FAIL b2b_idle_gap_busy got=%0b exp=0", busy); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL b2b_idle_gap_rv got=%0b exp=1", result_valid); else n_pass++;
        scan_drive(1'b0, lat, ok, rv0);
        n_total++; if (rv0 !== 1'b0) $display("FAIL b2b_rv_cleared got=%0b exp=0", rv0); else n_pass++;
        n_total++; if (lat !== 10) $display("FAIL b2b_second_latency got=%0d exp=10", lat); else n_pass++;
        n_total++; if (ok !== 1'b1) $display("FAIL b2b_second_raddr got=%0b exp=1", ok); else n_pass++;
        n_total++; if (class_idx !== 4'd9) $display("FAIL b2b_second_class got=%0d exp=9", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd700) $display("FAIL b2b_second_max got=%0d exp=700", max_val); else n_pass++;
`ifdef ELM_M3_MARGIN_EN
        n_total++; if (margin !== 32'd692) $display("FAIL b2b_second_margin got=%0d exp=692", margin); else n_pass++;
`endif
        tick();
    endtask

    task automatic test_ignore_start();
        int n_over;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 32'(i * 10);
        scores[7] = 32'sd5000;
        n_over = 0;
        start = 1'b1;
        tick();
        for (int c = 0; c < 30; c++) begin
            if (OVER === 1'b1) n_over++;
            start = (c == 4);
            tick();
        end
        start = 1'b0;
        n_total++; if (n_over !== 1) $display("FAIL ignore_over_count got=%0d exp=1", n_over); else n_pass++;
        n_total++; if (class_idx !== 4'd7) $display("FAIL ignore_class got=%0d exp=7", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd5000) $display("FAIL ignore_max got=%0d exp=5000", max_val); else n_pass++;
        n_total++; if (busy !== 1'b0) $display("FAIL ignore_busy_end got=%0b exp=0", busy); else n_pass++;
    endtask

    task automatic test_reset_mid_scan();
        int lat; bit ok; bit rv0; int n_over;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (6) tick();
        n_total++; if (raddr !== 4'd6) $display("FAIL rstmid_pre_raddr got=%0d exp=6", raddr); else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (busy !== 1'b0) $display("FAIL rstmid_busy got=%0b exp=0", busy); else n_pass++;
        n_total++; if (raddr !== 4'd0) $display("FAIL rstmid_raddr got=%0d exp=0", raddr); else n_pass++;
        n_total++; if (class_idx !== 4'd0) $display("FAIL rstmid_class got=%0d exp=0", class_idx); else n_pass++;
        n_total++; if (max_val !== 32'sd0) $display("FAIL rstmid_max got=%0d exp=0", max_val); else n_pass++;
        n_total++; if (result_valid !== 1'b0) $display("FAIL rstmid_rv got=%0b exp=0", result_valid); else n_pass++;
        n_over = 0;
        for (int c = 0; c < 15; c++) begin
            if (OVER === 1'b1) n_over++;
            tick();
        end
        n_total++; if (n_over !== 0) $display("FAIL rstmid_no_over got=%0d exp=0", n_over); else n_pass++;
        clear_scores();
        for (int i = 0; i < 10; i++) scores[i] = 32'(100 + i);
        scores[2] = 32'sd300;
        scores[5] = 32'sd300;
        scan_drive(1'b0, lat, ok, rv0);
        n_total++; if (lat !== 10) $display("FAIL rstmid_after_latency got=%0d exp=10", lat); else n_pass++;
        n_total++; if (class_idx !== 4'd2) $display("FAIL rstmid_after_class got=%0d exp=2", class_idx); else n_pass++;
        n_total++; if (result_valid !== 1'b1) $display("FAIL rstmid_after_rv got=%0b exp=1", result_valid); else n_pass++;
        tick();
    endtask

    initial begin
        clear_scores();
        test_reset();
        test_distinct();
        test_negative();
        test_tie();
        test_back_to_back();
        test_ignore_start();
        test_reset_mid_scan();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
